cpu_bus_responder: RTL

Responder end of the CPU memory bus: accepts the address/strobe signals driven by `cpu` and returns read data with `data_valid_o`. It serves 2 KiB of internal work RAM directly. It forwards program-ROM reads to an external memory port over a request/acknowledge handshake, and it applies RAM writes. It sits between `cpu` and the board memory controller and owns the CPU address map.

---
 rtl/cpu_bus_pkg.sv | 31 +++
 rtl/cpu_bus_responder_ram_sync.sv | 25 ++
 rtl/cpu_bus_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and address-map constants for the CPU bus responder.
// Decodes the 16-bit CPU address into RAM, open-bus and ROM regions.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_OPEN,
        REGION_ROM
    } bus_region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAM_READ,
        ST_ROM_WAIT,
        ST_VALID
    } bus_state_t;

    localparam logic [15:0] RAM_LIMIT      = 16'h1FFF;
    localparam logic [15:0] ROM_BASE       = 16'h8000;
    localparam logic [7:0]  OPEN_BUS_VALUE = 8'hFF;

    function automatic bus_region_t region_of(input logic [15:0] address);
        if (address <= RAM_LIMIT) begin
            return REGION_RAM;
        end else if (address >= ROM_BASE) begin
            return REGION_ROM;
        end
        return REGION_OPEN;
    endfunction

endpackage

// File: rtl/cpu_bus_responder_ram_sync.sv
// Single-port synchronous work RAM with a registered read port.
// A write returns the written byte on the read port (write-first).
module ram_sync #(
    parameter int ADDRESS_BITS = 11
) (
    input  logic                    clock_i,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic                    write_enable,
    input  logic [7:0]              write_data,
    output logic [7:0]              read_data
);

    logic [7:0] mem [0:(1 << ADDRESS_BITS) - 1];

    // Write-first, so a read issued in the same cycle as a write sees the new byte.
    always_ff @(posedge clock_i) begin
        if (write_enable) begin
            mem[address] <= write_data;
            read_data    <= write_data;
        end else begin
            read_data <= mem[address];
        end
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// Responder for the CPU memory bus: internal RAM, open bus, external ROM port.
// Holds the served address so data_valid_o is never shown for a stale address.
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int RAM_ADDRESS_BITS   = 11,
    parameter int ROM_TIMEOUT_CYCLES = 255
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [15:0] address_i,
    input  logic        address_valid_i,
    input  logic [7:0]  data_i,
    input  logic        data_valid_i,
    output logic [7:0]  data_o,
    output logic        data_valid_o,
    // ROM handshake: rom_request_o rises with rom_address_o loaded and stays high
    // until the cycle rom_ack_i is seen (data taken that cycle) or the wait times out.
    output logic [14:0] rom_address_o,
    output logic        rom_request_o,
    input  logic [7:0]  rom_data_i,
    input  logic        rom_ack_i,
    output logic        bus_error_o,
    output logic [1:0]  state_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(ROM_TIMEOUT_CYCLES - 1);

    bus_state_t  state_q, state_d;
    bus_region_t region;
    logic [15:0] served_address_q, served_address_d;
    logic        served_q, served_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        rom_request_q, rom_request_d;
    logic [14:0] rom_address_q, rom_address_d;
    logic        bus_error_q, bus_error_d;
    logic [7:0]  timeout_count_q, timeout_count_d;
    logic        new_read;
    logic        ram_write;
    logic        coherent_write;
    logic [7:0]  ram_read_data;

    assign region         = region_of(address_i);
    assign new_read       = (state_q == ST_IDLE || state_q == ST_VALID) && address_valid_i &&
                            (!served_q || address_i != served_address_q);
    assign ram_write      = address_valid_i && data_valid_i && region == REGION_RAM;
    assign coherent_write = ram_write && served_q && address_i == served_address_q;

    ram_sync #(
        .ADDRESS_BITS(RAM_ADDRESS_BITS)
    ) u_ram (
        .clock_i     (clock_i),
        .address     (address_i[RAM_ADDRESS_BITS-1:0]),
        .write_enable(ram_write),
        .write_data  (data_i),
        .read_data   (ram_read_data)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q          <= ST_IDLE;
            served_address_q <= 16'h0000;
            served_q         <= 1'b0;
            valid_q          <= 1'b0;
            data_q           <= 8'h00;
            rom_request_q    <= 1'b0;
            rom_address_q    <= 15'h0000;
            bus_error_q      <= 1'b0;
            timeout_count_q  <= 8'h00;
        end else begin
            state_q          <= state_d;
            served_address_q <= served_address_d;
            served_q         <= served_d;
            valid_q          <= valid_d;
            data_q           <= data_d;
            rom_request_q    <= rom_request_d;
            rom_address_q    <= rom_address_d;
            bus_error_q      <= bus_error_d;
            timeout_count_q  <= timeout_count_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        served_address_d = served_address_q;
        served_d         = served_q;
        valid_d          = valid_q;
        data_d           = data_q;
        rom_request_d    = rom_request_q;
        rom_address_d    = rom_address_q;
        bus_error_d      = bus_error_q;
        timeout_count_d  = timeout_count_q;

        case (state_q)
            ST_IDLE, ST_VALID: begin
                if (new_read) begin
                    served_address_d = address_i;
                    served_d         = 1'b1;
                    case (region)
                        REGION_RAM: begin
                            state_d = ST_RAM_READ;
                            valid_d = 1'b0;
                        end
                        REGION_ROM: begin
                            state_d         = ST_ROM_WAIT;
                            valid_d         = 1'b0;
                            rom_request_d   = 1'b1;
                            rom_address_d   = address_i[14:0];
                            timeout_count_d = 8'h00;
                        end
                        default: begin
                            state_d = ST_VALID;
                            valid_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_RAM_READ: begin
                state_d = ST_VALID;
                valid_d = 1'b1;
                data_d  = ram_read_data;
            end
            ST_ROM_WAIT: begin
                // Ack wins over a timeout landing in the same cycle.
                if (rom_ack_i) begin
                    state_d       = ST_VALID;
                    valid_d       = 1'b1;
                    data_d        = rom_data_i;
                    rom_request_d = 1'b0;
                end else if (timeout_count_q == TIMEOUT_LAST) begin
                    state_d       = ST_VALID;
                    valid_d       = 1'b1;
                    data_d        = OPEN_BUS_VALUE;
                    rom_request_d = 1'b0;
                    bus_error_d   = 1'b1;
                end else begin
                    timeout_count_d = timeout_count_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A write to the byte currently being served keeps data_o coherent.
        if (coherent_write) begin
            data_d = data_i;
        end
    end

    assign data_o        = data_q;
    assign data_valid_o  = valid_q & served_q & (address_i == served_address_q) & address_valid_i;
    assign rom_address_o = rom_address_q;
    assign rom_request_o = rom_request_q;
    assign bus_error_o   = bus_error_q;
    assign state_o       = state_q;

endmodule
